// File: rtl/rvfi_mem_responder.sv
// Memory-side responder for the native mem_valid/mem_ready interface: bounded random latency,
// a small tagged word store for consistent re-reads, and a sticky core protocol error flag.
module rvfi_mem_responder #(
    parameter int unsigned MIN_LATENCY = 1,
    parameter int unsigned MAX_LATENCY = 4,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned DEPTH       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic [LAT_W-1:0] rand_latency,
    input  logic [31:0]      rand_rdata,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             protocol_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned TAG_W = 30 - IDX_W;
    localparam int unsigned SPAN  = MAX_LATENCY - MIN_LATENCY;
    localparam int unsigned CNT_W = (MAX_LATENCY > 1) ? $clog2(MAX_LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               instr_q, instr_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [31:0]        line_q, line_d;
    logic               err_q, err_d;

    logic               valid_q [DEPTH];
    logic [TAG_W-1:0]   tag_q   [DEPTH];
    logic [31:0]        data_q  [DEPTH];

    logic [29:0]        req_waddr;
    logic [31:0]        req_wdata;
    logic [3:0]         req_wstrb;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               hit;
    logic [31:0]        base;
    logic [31:0]        merged;
    logic               fld_diff;
    int unsigned        lat_sel;
    int unsigned        lat_m1;

    logic               unused_addr_lsbs;
    assign unused_addr_lsbs = ^mem_addr[1:0];

    // In IDLE the request is still on the inputs; afterwards use the latched copy.
    always_comb begin
        req_waddr = (state_q == IDLE) ? mem_addr[31:2] : waddr_q;
        req_wdata = (state_q == IDLE) ? mem_wdata      : wdata_q;
        req_wstrb = (state_q == IDLE) ? mem_wstrb      : wstrb_q;
        req_idx   = req_waddr[IDX_W-1:0];
        req_tag   = req_waddr[29:IDX_W];
        hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        base      = hit ? data_q[req_idx] : rand_rdata;
        merged    = base;
        for (int unsigned b = 0; b < 4; b++) begin
            if (req_wstrb[b]) merged[8*b +: 8] = req_wdata[8*b +: 8];
        end
        fld_diff  = (mem_addr[31:2] != waddr_q) || (mem_wdata != wdata_q) ||
                    (mem_wstrb != wstrb_q) || (mem_instr != instr_q);
        lat_sel   = (32'(rand_latency) > SPAN) ? SPAN : 32'(rand_latency);
        lat_m1    = MIN_LATENCY - 1 + lat_sel;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        instr_d = instr_q;
        err_d   = err_q;
        line_d  = line_q;
        rdata_d = '0;
        case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    waddr_d = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    if (mem_instr && (mem_wstrb != 4'h0)) err_d = 1'b1;
                    cnt_d = CNT_W'(lat_m1);
                    state_d = (lat_m1 == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!mem_valid || fld_diff) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                if (mem_valid && fld_diff) err_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Response data and the new store line are captured on entry to RESP so outputs stay registered.
        if (state_d == RESP && state_q != RESP) begin
            line_d  = merged;
            rdata_d = (req_wstrb == 4'h0) ? merged : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            line_q  <= '0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            line_q  <= line_d;
            err_q   <= err_d;
            if (state_q == RESP) begin
                valid_q[waddr_q[IDX_W-1:0]] <= 1'b1;
                tag_q[waddr_q[IDX_W-1:0]]   <= waddr_q[29:IDX_W];
                data_q[waddr_q[IDX_W-1:0]]  <= line_q;
            end
        end
    end

    assign mem_ready    = (state_q == RESP);
    assign mem_rdata    = rdata_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_rvfi_mem_responder.sv
// Scoreboard bench for rvfi_mem_responder: directed scenarios plus randomized traffic checked
// against a behavioural word-store model with the clamped-latency rule.
module tb_rvfi_mem_responder;

    localparam int unsigned MIN_L = 1;
    localparam int unsigned MAX_L = 4;
    localparam int unsigned LW    = 3;
    localparam int unsigned DEP   = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_valid;
    logic          mem_instr;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [LW-1:0] rand_latency;
    logic [31:0]   rand_rdata;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          protocol_err;

    rvfi_mem_responder #(
        .MIN_LATENCY(MIN_L),
        .MAX_LATENCY(MAX_L),
        .LAT_W(LW),
        .DEPTH(DEP)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_valid(mem_valid),
        .mem_instr(mem_instr),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .rand_latency(rand_latency),
        .rand_rdata(rand_rdata),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        exp_err = 1'b0;

    bit          m_valid [DEP];
    int unsigned m_tag   [DEP];
    logic [31:0] m_data  [DEP];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every cycle out of reset, compare DUT responses with the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                check("resp_missing", 32'(exp_q[0].cyc), 32'(cyc));
                void'(exp_q.pop_front());
            end
            if (mem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", {31'b0, mem_ready}, 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.cyc));
                    check("resp_rdata", mem_rdata, e.rdata);
                end
            end else begin
                check("rdata_idle", mem_rdata, 32'h0);
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < int'(DEP); i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_data[i]  = '0;
        end
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic idle(input int n);
        mem_valid = 1'b0;
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_wstrb = 4'($urandom);
        mem_instr = 1'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the first cycle a new request may be accepted.
    task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                          input logic instr, input int unsigned lat, input logic [31:0] fill);
        int unsigned L, idx, tag;
        logic [31:0] base, merged;
        exp_t e;
        mem_valid    = 1'b1;
        mem_addr     = addr;
        mem_wdata    = wdata;
        mem_wstrb    = wstrb;
        mem_instr    = instr;
        rand_latency = LW'(lat);
        rand_rdata   = fill;
        L   = MIN_L + ((lat > MAX_L - MIN_L) ? (MAX_L - MIN_L) : lat);
        idx = (addr >> 2) % DEP;
        tag = addr >> (2 + $clog2(DEP));
        base = (m_valid[idx] && m_tag[idx] == tag) ? m_data[idx] : fill;
        merged = base;
        for (int b = 0; b < 4; b++) if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        m_data[idx]  = merged;
        e.cyc   = cyc + L;
        e.rdata = (wstrb == 4'h0) ? base : 32'h0;
        exp_q.push_back(e);
        if (instr && wstrb != 4'h0) exp_err = 1'b1;
        @(posedge clk);
        #1;
        rand_latency = LW'($urandom);
        repeat (L) @(posedge clk);
        #1;
    endtask

    task automatic check_err(input string name);
        @(negedge clk);
        check(name, {31'b0, protocol_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        check("rst_ready", {31'b0, mem_ready}, 32'h0);
        check("rst_rdata", mem_rdata, 32'h0);
        check("rst_err", {31'b0, protocol_err}, 32'h0);
        @(posedge clk);
        #1;
        model_clear();
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  s;
        logic        rd;
        reset = 1'b0;
        rand_latency = '0;
        rand_rdata = '0;
        model_clear();
        idle(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ready", {31'b0, mem_ready}, 32'h0);
        check("reset_rdata", mem_rdata, 32'h0);
        check("reset_err", {31'b0, protocol_err}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle(1);

        // read miss then re-read hit
        do_req(32'h100, 32'h0, 4'h0, 1'b0, 0, 32'hDEADBEEF); idle(1);
        do_req(32'h100, 32'h0, 4'h0, 1'b0, 0, 32'h12345678); idle(1);
        // partial write merge
        do_req(32'h200, 32'h11223344, 4'hF, 1'b0, 1, 32'hFFFFFFFF); idle(1);
        do_req(32'h200, 32'h0000AA00, 4'h2, 1'b0, 2, 32'h0); idle(1);
        do_req(32'h200, 32'h0, 4'h0, 1'b0, 0, 32'h0BAD0BAD); idle(1);
        // latency, including clamp of out-of-range value
        do_req(32'h400, 32'h0, 4'h0, 1'b0, 2, 32'hCAFE0001); idle(1);
        do_req(32'h404, 32'h0, 4'h0, 1'b1, 7, 32'hCAFE0002); idle(1);
        // eviction on same index, different tag
        do_req(32'h000, 32'hAAAAAAAA, 4'hF, 1'b0, 0, 32'h0); idle(1);
        do_req(32'h020, 32'h0, 4'h0, 1'b0, 1, 32'h5); idle(1);
        do_req(32'h000, 32'h0, 4'h0, 1'b0, 3, 32'h77); idle(1);
        check_err("err_clean");

        // address change during WAIT: abort without response
        mem_valid = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        mem_instr = 1'b0; rand_latency = LW'(3); rand_rdata = 32'h1;
        @(posedge clk); #1;
        mem_addr = 32'h504;
        exp_err = 1'b1;
        @(posedge clk); #1;
        idle(6);
        check_err("err_wait_change");
        pulse_reset();

        // instruction fetch with write strobe
        do_req(32'h600, 32'h12345678, 4'h1, 1'b1, 0, 32'h0); idle(1);
        check_err("err_instr_write");
        do_req(32'h600, 32'h0, 4'h0, 1'b0, 1, 32'h0); idle(3);
        check_err("err_sticky");

        // reset during WAIT of a write to 0x300
        mem_valid = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h55555555; mem_wstrb = 4'hF;
        mem_instr = 1'b0; rand_latency = LW'(3); rand_rdata = 32'h2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idle(0);
        pulse_reset();
        do_req(32'h300, 32'h0, 4'h0, 1'b0, 0, 32'h3C3C3C3C); idle(1);

        // randomized traffic with back-to-back requests
        for (int i = 0; i < 150; i++) begin
            a  = ($urandom_range(0, 31) << 2) | 32'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            s  = rd ? 4'h0 : 4'($urandom_range(1, 15));
            do_req(a, $urandom, s, rd ? 1'($urandom) : 1'b0, $urandom_range(0, 7), $urandom);
            idle($urandom_range(0, 2));
        end

        idle(6);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        check_err("err_final");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rvfi_mem_responder.md
# rvfi_mem_responder

Parametrised memory-side environment for the core's native memory interface (`mem_valid`/`mem_ready`), replacing free-running unconstrained `mem_ready`/`mem_rdata` in the formal wrapper.
- Returns each request after a bounded, solver-chosen latency.
- Keeps a small tagged word store, so re-reads of a written or previously read address return consistent data.
- Flags core-side protocol violations on a sticky error output.

Also usable as a simulation memory stub.

## Interface
Parameters:
- `MIN_LATENCY`, 1: minimum cycles from request accept to `mem_ready`; must be ≥1.
- `MAX_LATENCY`, 4: maximum cycles from accept to `mem_ready`; must be ≥ `MIN_LATENCY`.
- `LAT_W`, 3: width of `rand_latency`.
- `DEPTH`, 8: number of store entries; power of two, ≥2.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-low reset (asserted when 0).
- `mem_valid` in 1: core request valid.
- `mem_instr` in 1: request is an instruction fetch.
- `mem_addr` in 32: byte address; bits [1:0] are ignored.
- `mem_wdata` in 32: write data.
- `mem_wstrb` in 4: byte write enables; 0 means read.
- `rand_latency` in `LAT_W`: free input (rand reg in formal); sampled at accept.
- `rand_rdata` in 32: free input; supplies data for store misses.
- `mem_ready` out 1: one-cycle response strobe.
- `mem_rdata` out 32: read data, valid only while `mem_ready`=1 on a read.
- `protocol_err` out 1: sticky violation flag.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - On `mem_valid`=1, latch addr, wdata, wstrb and instr.
  - Compute L = `MIN_LATENCY` + min(`rand_latency`, `MAX_LATENCY`−`MIN_LATENCY`).
  - Load the down-counter with L−1.
  - Go to WAIT, or straight to RESP if L=1.
- WAIT:
  - Decrement the counter; go to RESP when it reaches 0.
  - `mem_valid` must stay 1 and addr/wdata/wstrb/instr must stay equal to the latched values. Any deviation sets `protocol_err` and returns to IDLE with no response.
- RESP:
  - `mem_ready`=1 for exactly this cycle.
  - Next state is always IDLE. The earliest new accept is the following cycle.
- Protocol violations (each sets `protocol_err`):
  - The WAIT deviations above.
  - `mem_instr`=1 with `mem_wstrb`≠0 at accept.
  - `mem_valid`=1 while in RESP with any field changed.
- `protocol_err` clears only on reset.
- Store:
  - `DEPTH` entries, each holding a valid bit, a tag and 32 data bits.
  - Index = `mem_addr[log2(DEPTH)+1:2]`; tag = `mem_addr[31:log2(DEPTH)+2]`.
  - Hit = entry valid and tag equal.
- Store update happens in the RESP cycle:
  - Read hit: `mem_rdata` = entry data; no update.
  - Read miss: `mem_rdata` = `rand_rdata`; entry is written with the new tag and `rand_rdata` and marked valid, evicting any previous occupant.
  - Write hit: merge the strobed bytes of the latched wdata into the entry.
  - Write miss: entry = strobed bytes from wdata, unstrobed bytes from `rand_rdata`; new tag; valid.
  - On writes, `mem_rdata` = 0.
- Instruction fetches and data accesses share the store.

## Timing
- Reset values:
  - State = IDLE.
  - `mem_ready`=0.
  - `mem_rdata`=0.
  - `protocol_err`=0.
  - All store valid bits = 0.
  - Counter = 0.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction with no `mem_ready` and no store update.
- All outputs are registered, or decoded purely from registered state; there is no combinational path from inputs to `mem_ready`.
- Latency: if `mem_valid` rises in cycle t (IDLE), `mem_ready` is 1 in cycle t+L.
- Out-of-range `rand_latency` is clamped to `MAX_LATENCY`.
- Back-to-back: the minimum request spacing is L+1 cycles.
- `mem_rdata` is 0 in every cycle where `mem_ready`=0.

## Test plan
- Read miss/re-read:
  - Read 0x100 with `rand_latency`=0 and `rand_rdata`=0xDEADBEEF, giving `mem_ready` at t+1 with rdata 0xDEADBEEF.
  - Read 0x100 again with `rand_rdata`=0x12345678, which must return 0xDEADBEEF.
- Partial write merge:
  - Write 0x200 with wstrb=0xF and wdata=0x11223344.
  - Write 0x200 with wstrb=0x2 and wdata=0x0000AA00.
  - Reading 0x200 must return 0x1122AA44.
- Latency bounds (MIN=1, MAX=4):
  - `rand_latency`=2 gives `mem_ready` at t+3.
  - `rand_latency`=7 is clamped, giving `mem_ready` at t+4.
  - `mem_ready` is high for exactly one cycle in each case.
- Eviction (DEPTH=8):
  - Write 0x000 with 0xAAAAAAAA, then read 0x020 (same index, different tag) with `rand_rdata`=0x5.
  - Reading 0x000 with `rand_rdata`=0x77 must return 0x77.
- Protocol errors:
  - Changing `mem_addr` during WAIT sets `protocol_err`=1, gives no `mem_ready`, and returns to IDLE.
  - A fetch with `mem_instr`=1 and wstrb=0x1 sets `protocol_err`.
  - `protocol_err` stays 1 until `reset`=0.
- Reset mid-transaction:
  - Drive `reset`=0 during WAIT of a write to 0x300. All outputs return to 0 immediately.
  - A later read of 0x300 is a miss and returns `rand_rdata`.
